// File: rtl/rgb_mixer_pkg.sv
// Shared constants and types for the RGB mixer: duty word width (matches the encoder
// output) and the default PWM tick prescale.
package rgb_mixer_pkg;

  localparam int unsigned DUTY_WIDTH       = 8;
  localparam int unsigned DEFAULT_PRESCALE = 1;

  typedef logic [DUTY_WIDTH-1:0] duty_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prescaler.sv
// Divides clk into a one-cycle tick every PRESCALE enabled cycles; holds at zero while
// disabled so the first tick lands exactly PRESCALE cycles after enable rises.
module prescaler
  import rgb_mixer_pkg::*;
#(
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned   CntW = cnt_width(PRESCALE);
  localparam logic [CntW-1:0] Last = CntW'(PRESCALE - 1);

  logic [CntW-1:0] pre_cnt_q, pre_cnt_d;

  assign tick = enable && (pre_cnt_q == Last);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (!enable || tick) begin
      pre_cnt_d = '0;
    end else begin
      pre_cnt_d = pre_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_channel.sv
// Single-colour PWM channel. Duty is double-buffered into a shadow register that only
// reloads at the period wrap (or continuously while idle), so updates never cause runts.
module pwm_channel
  import rgb_mixer_pkg::*;
#(
  parameter int unsigned WIDTH    = DUTY_WIDTH,
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE,
  parameter bit          INVERT   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] duty,
  output logic             pwm_out,
  output logic             period_done,
  output logic [WIDTH-1:0] duty_active
);

  localparam logic [WIDTH-1:0] CntMax = '1;

  logic             tick;
  logic             wrap;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             pwm_q, pwm_d;
  logic             done_q, done_d;

  prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .tick  (tick)
  );

  assign wrap = tick && (cnt_q == CntMax);

  always_comb begin
    cnt_d  = cnt_q;
    duty_d = duty_q;
    pwm_d  = INVERT;
    done_d = 1'b0;
    if (!enable) begin
      // Idle: abandon the period and track duty so enabling starts with the current value.
      cnt_d  = '0;
      duty_d = duty;
    end else begin
      pwm_d  = (cnt_q < duty_q) ^ INVERT;
      done_d = wrap;
      if (tick) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (wrap) begin
        duty_d = duty;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= INVERT;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
      done_q <= done_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign period_done = done_q;
  assign duty_active = duty_q;

endmodule

// File: tb/tb_pwm_channel.sv
// Bench for pwm_channel: per-period expectations (high count, first transition, wrap
// pulses) are queued when duty/enable are driven and popped as each period is measured.
module tb_pwm_channel;

  typedef struct {
    int highs;
    int idx;
    int pds;
    bit last_pd;
  } exp_t;

  logic       clk = 1'b0;
  logic       a_reset, a_enable, a_pwm, a_pd;
  logic [7:0] a_duty, a_da;
  logic       b_reset, b_enable, b_pwm, b_pd;
  logic [7:0] b_duty, b_da;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pwm_channel #(
    .WIDTH   (8),
    .PRESCALE(1),
    .INVERT  (1'b0)
  ) u_dut_a (
    .clk        (clk),
    .reset      (a_reset),
    .enable     (a_enable),
    .duty       (a_duty),
    .pwm_out    (a_pwm),
    .period_done(a_pd),
    .duty_active(a_da)
  );

  pwm_channel #(
    .WIDTH   (8),
    .PRESCALE(4),
    .INVERT  (1'b1)
  ) u_dut_b (
    .clk        (clk),
    .reset      (b_reset),
    .enable     (b_enable),
    .duty       (b_duty),
    .pwm_out    (b_pwm),
    .period_done(b_pd),
    .duty_active(b_da)
  );

  // Full period at PRESCALE=1, active-high: D highs, first change at D, one wrap at the end.
  function automatic exp_t exp_a(input int d);
    exp_t e;
    e.highs   = d;
    e.idx     = (d == 0) ? 256 : d;
    e.pds     = 1;
    e.last_pd = 1'b1;
    return e;
  endfunction

  // Full period at PRESCALE=4, active-low: 4*D low clocks then high for the rest.
  function automatic exp_t exp_b(input int d);
    exp_t e;
    e.highs   = 1024 - 4 * d;
    e.idx     = (d == 0) ? 1024 : 4 * d;
    e.pds     = 1;
    e.last_pd = 1'b1;
    return e;
  endfunction

  function automatic exp_t exp_part(input int highs, input int idx);
    exp_t e;
    e.highs   = highs;
    e.idx     = idx;
    e.pds     = 0;
    e.last_pd = 1'b0;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Samples n clocks #1 after each edge: high count, wrap pulses, first index differing
  // from the first sample (n if none), and period_done on the final sample.
  task automatic measure(input bit sel, input int n, output int highs, output int pds,
                         output int idx, output bit last_pd);
    bit first, p, d;
    highs   = 0;
    pds     = 0;
    idx     = n;
    first   = 1'b0;
    last_pd = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      p = sel ? b_pwm : a_pwm;
      d = sel ? b_pd : a_pd;
      if (i == 0) first = p;
      else if (idx == n && p != first) idx = i;
      highs += int'(p);
      pds   += int'(d);
      last_pd = d;
    end
  endtask

  task automatic test_reset();
    a_reset  = 1'b1;
    a_enable = 1'b0;
    a_duty   = 8'd64;
    repeat (2) step();
    checks += 3;
    if (a_pwm !== 1'b0) begin failures++; $display("FAIL reset_pwm: got %b want 0", a_pwm); end
    if (a_pd !== 1'b0) begin failures++; $display("FAIL reset_pd: got %b want 0", a_pd); end
    if (a_da !== 8'd0) begin failures++; $display("FAIL reset_da: got %0d want 0", a_da); end
    a_reset = 1'b0;
    step();
    checks++;
    if (a_da !== 8'd64) begin failures++; $display("FAIL idle_load_da: got %0d want 64", a_da); end
  endtask

  // Runs np full A periods, comparing each against the next queued expectation.
  task automatic run_a_periods(input string name, input int np);
    int   highs, pds, idx;
    bit   lpd;
    exp_t e;
    for (int p = 0; p < np; p++) begin
      measure(1'b0, 256, highs, pds, idx, lpd);
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL %s_sb: scoreboard empty at period %0d", name, p);
      end else begin
        e = exp_q.pop_front();
        checks += 4;
        if (highs !== e.highs) begin
          failures++; $display("FAIL %s_highs[%0d]: got %0d want %0d", name, p, highs, e.highs);
        end
        if (idx !== e.idx) begin
          failures++; $display("FAIL %s_edge[%0d]: got %0d want %0d", name, p, idx, e.idx);
        end
        if (pds !== e.pds) begin
          failures++; $display("FAIL %s_pd_cnt[%0d]: got %0d want %0d", name, p, pds, e.pds);
        end
        if (lpd !== e.last_pd) begin
          failures++; $display("FAIL %s_pd_pos[%0d]: got %b want %b", name, p, lpd, e.last_pd);
        end
      end
    end
  endtask

  task automatic test_basic_duty();
    a_enable = 1'b1;
    exp_q.push_back(exp_a(64));
    exp_q.push_back(exp_a(64));
    run_a_periods("basic", 2);
    checks++;
    if (a_da !== 8'd64) begin failures++; $display("FAIL basic_da: got %0d want 64", a_da); end
  endtask

  task automatic test_extremes();
    a_duty = 8'd0;
    exp_q.push_back(exp_a(64));
    repeat (3) exp_q.push_back(exp_a(0));
    run_a_periods("duty0", 4);
    a_duty = 8'd255;
    exp_q.push_back(exp_a(0));
    exp_q.push_back(exp_a(255));
    exp_q.push_back(exp_a(255));
    run_a_periods("duty255", 3);
  endtask

  task automatic test_mid_period_update();
    int   h1, h2, h3, p1, p2, p3, idx;
    bit   lpd;
    exp_t e;
    a_duty = 8'd128;
    exp_q.push_back(exp_a(255));
    exp_q.push_back(exp_a(128));
    run_a_periods("mid_pre", 2);
    exp_q.push_back(exp_a(128));
    measure(1'b0, 50, h1, p1, idx, lpd);
    a_duty = 8'd32;
    measure(1'b0, 205, h2, p2, idx, lpd);
    checks++;
    if (a_da !== 8'd128) begin failures++; $display("FAIL mid_da_hold: got %0d want 128", a_da); end
    measure(1'b0, 1, h3, p3, idx, lpd);
    checks++;
    if (a_da !== 8'd32) begin failures++; $display("FAIL mid_da_wrap: got %0d want 32", a_da); end
    if (exp_q.size() == 0) begin
      checks++; failures++; $display("FAIL mid_sb: scoreboard empty");
    end else begin
      e = exp_q.pop_front();
      checks += 3;
      if (h1 + h2 + h3 !== e.highs) begin
        failures++; $display("FAIL mid_highs: got %0d want %0d", h1 + h2 + h3, e.highs);
      end
      if (p1 + p2 + p3 !== e.pds) begin
        failures++; $display("FAIL mid_pd_cnt: got %0d want %0d", p1 + p2 + p3, e.pds);
      end
      if (lpd !== e.last_pd) begin
        failures++; $display("FAIL mid_pd_pos: got %b want %b", lpd, e.last_pd);
      end
    end
    exp_q.push_back(exp_a(32));
    run_a_periods("mid_post", 1);
  endtask

  task automatic test_enable_gating();
    a_duty = 8'd150;
    exp_q.push_back(exp_a(32));
    run_a_periods("en_pre", 1);
    exp_q.push_back(exp_part(100, 100));
    run_part("en_partial", 100);
    a_enable = 1'b0;
    a_duty   = 8'd200;
    step();
    checks += 3;
    if (a_pwm !== 1'b0) begin failures++; $display("FAIL en_off_pwm: got %b want 0", a_pwm); end
    if (a_pd !== 1'b0) begin failures++; $display("FAIL en_off_pd: got %b want 0", a_pd); end
    if (a_da !== 8'd200) begin failures++; $display("FAIL en_off_da: got %0d want 200", a_da); end
    exp_q.push_back(exp_part(0, 300));
    run_part("en_idle", 300);
    a_enable = 1'b1;
    exp_q.push_back(exp_a(200));
    exp_q.push_back(exp_a(200));
    run_a_periods("en_resume", 2);
  endtask

  // Partial A window of n clocks compared against the next queued expectation.
  task automatic run_part(input string name, input int n);
    int   highs, pds, idx;
    bit   lpd;
    exp_t e;
    measure(1'b0, n, highs, pds, idx, lpd);
    if (exp_q.size() == 0) begin
      checks++; failures++; $display("FAIL %s_sb: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      checks += 3;
      if (highs !== e.highs) begin
        failures++; $display("FAIL %s_highs: got %0d want %0d", name, highs, e.highs);
      end
      if (idx !== e.idx) begin
        failures++; $display("FAIL %s_edge: got %0d want %0d", name, idx, e.idx);
      end
      if (pds !== e.pds) begin
        failures++; $display("FAIL %s_pd_cnt: got %0d want %0d", name, pds, e.pds);
      end
    end
  endtask

  task automatic test_prescale_invert();
    int   highs, pds, idx;
    bit   lpd;
    exp_t e;
    checks += 3;
    if (b_pwm !== 1'b1) begin failures++; $display("FAIL inv_reset_pwm: got %b want 1", b_pwm); end
    if (b_pd !== 1'b0) begin failures++; $display("FAIL inv_reset_pd: got %b want 0", b_pd); end
    if (b_da !== 8'd0) begin failures++; $display("FAIL inv_reset_da: got %0d want 0", b_da); end
    b_duty  = 8'd10;
    b_reset = 1'b0;
    step();
    b_enable = 1'b1;
    exp_q.push_back(exp_b(10));
    exp_q.push_back(exp_b(10));
    for (int p = 0; p < 2; p++) begin
      measure(1'b1, 1024, highs, pds, idx, lpd);
      if (exp_q.size() == 0) begin
        checks++; failures++; $display("FAIL inv_sb: scoreboard empty at period %0d", p);
      end else begin
        e = exp_q.pop_front();
        checks += 4;
        if (highs !== e.highs) begin
          failures++; $display("FAIL inv_highs[%0d]: got %0d want %0d", p, highs, e.highs);
        end
        if (idx !== e.idx) begin
          failures++; $display("FAIL inv_edge[%0d]: got %0d want %0d", p, idx, e.idx);
        end
        if (pds !== e.pds) begin
          failures++; $display("FAIL inv_pd_cnt[%0d]: got %0d want %0d", p, pds, e.pds);
        end
        if (lpd !== e.last_pd) begin
          failures++; $display("FAIL inv_pd_pos[%0d]: got %b want %b", p, lpd, e.last_pd);
        end
      end
    end
    checks++;
    if (b_da !== 8'd10) begin failures++; $display("FAIL inv_da: got %0d want 10", b_da); end
  endtask

  task automatic test_reset_mid();
    a_duty = 8'd100;
    exp_q.push_back(exp_part(77, 77));
    run_part("rst_pre", 77);
    a_reset = 1'b1;
    step();
    checks += 3;
    if (a_pwm !== 1'b0) begin failures++; $display("FAIL rst_mid_pwm: got %b want 0", a_pwm); end
    if (a_pd !== 1'b0) begin failures++; $display("FAIL rst_mid_pd: got %b want 0", a_pd); end
    if (a_da !== 8'd0) begin failures++; $display("FAIL rst_mid_da: got %0d want 0", a_da); end
    a_reset = 1'b0;
    // Enable stayed high, so the first post-reset period runs with the cleared shadow.
    exp_q.push_back(exp_a(0));
    exp_q.push_back(exp_a(100));
    run_a_periods("rst_resume", 2);
  endtask

  initial begin
    a_reset  = 1'b1;
    a_enable = 1'b0;
    a_duty   = 8'd0;
    b_reset  = 1'b1;
    b_enable = 1'b0;
    b_duty   = 8'd0;
    test_reset();
    test_basic_duty();
    test_extremes();
    test_mid_period_update();
    test_enable_gating();
    test_prescale_invert();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
